// File: rtl/trace_uart_tx_if.sv
// Trace peek bundle carried from the CPU debug outputs into the
// trace transmitter.
interface trace_uart_tx_if;
   logic        enable;
   logic [1:0]  step;
   logic [15:0] pc_peek;
   logic [15:0] r1_peek;

   modport master (
      output enable,
      output step,
      output pc_peek,
      output r1_peek
   );

   modport slave (
      input enable,
      input step,
      input pc_peek,
      input r1_peek
   );
endinterface

// File: rtl/trace_uart_tx.sv
// Execution-trace transmitter: captures one {pc, r1} record per
// instruction and ships it as a 5-byte 8N1 UART frame.
module trace_uart_tx #(
   parameter int CLOCK_DIV  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clock_input,
   input  logic                         reset,
   trace_uart_tx_if.slave               trc,
   output logic                         tx,
   output logic                         busy,
   output logic                         overflow,
   output logic [7:0]                   dropped_count,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [15:0]   BAUD_RELOAD = 16'(CLOCK_DIV - 1);
   localparam logic [LW-1:0] FULL_LVL    = LW'(FIFO_DEPTH);
   localparam logic [7:0]    SYNC_BYTE   = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   logic [1:0]    step_prev_q;
   logic          capture;

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          drop;

   logic          overflow_q;
   logic          overflow_d;
   logic [7:0]    drop_q;
   logic [7:0]    drop_d;

   state_e        state_q;
   state_e        state_d;
   logic [15:0]   baud_q;
   logic [15:0]   baud_d;
   logic [2:0]    bit_q;
   logic [2:0]    bit_d;
   logic [2:0]    bit_nxt;
   logic [2:0]    byte_q;
   logic [2:0]    byte_d;
   logic [31:0]   frame_q;
   logic [31:0]   frame_d;
   logic          tx_q;
   logic          tx_d;
   logic [7:0]    cur_byte;
   logic          baud_tick;

   // A capture marks the entry into step 1, so each instruction
   // contributes exactly one record.
   assign capture = trc.enable
                 && (trc.step == 2'h1)
                 && (step_prev_q == 2'h0);

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == FULL_LVL);
   assign push       = capture && (!fifo_full || pop);
   assign drop       = capture && fifo_full && !pop;

   always_comb begin
      level_d = level_q;
      unique case (1'b1)
         push && !pop: level_d = level_q + LW'(1);
         pop && !push: level_d = level_q - LW'(1);
         default:      level_d = level_q;
      endcase
   end

   always_comb begin
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   always_comb begin
      cur_byte = SYNC_BYTE;
      unique case (byte_q)
         3'd0:    cur_byte = SYNC_BYTE;
         3'd1:    cur_byte = frame_q[31:24];
         3'd2:    cur_byte = frame_q[23:16];
         3'd3:    cur_byte = frame_q[15:8];
         default: cur_byte = frame_q[7:0];
      endcase
   end

   assign baud_tick = (baud_q == 16'd0);
   assign bit_nxt   = bit_q + 3'd1;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      frame_d = frame_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               frame_d = mem_q[rd_ptr_q];
               byte_d  = 3'd0;
               bit_d   = 3'd0;
               baud_d  = BAUD_RELOAD;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (baud_tick) begin
               baud_d  = BAUD_RELOAD;
               bit_d   = 3'd0;
               tx_d    = cur_byte[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         DATA: begin
            if (baud_tick) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d = bit_nxt;
                  tx_d  = cur_byte[bit_nxt];
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         STOP: begin
            if (baud_tick) begin
               baud_d = BAUD_RELOAD;
               if (byte_q < 3'd4) begin
                  byte_d  = byte_q + 3'd1;
                  tx_d    = 1'b0;
                  state_d = START;
               end else if (!fifo_empty) begin
                  // Chain straight into the next frame with no idle gap.
                  pop     = 1'b1;
                  frame_d = mem_q[rd_ptr_q];
                  byte_d  = 3'd0;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clock_input) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {trc.pc_peek, trc.r1_peek};
      end
   end

   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         step_prev_q <= 2'h0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         drop_q      <= 8'h00;
      end else begin
         step_prev_q <= trc.step;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         drop_q      <= drop_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Reset abandons any frame in flight and forces the line idle.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         byte_q  <= 3'd0;
         frame_q <= 32'd0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         frame_q <= frame_d;
         tx_q    <= tx_d;
      end
   end

   assign tx            = tx_q;
   assign busy          = (state_q != IDLE) || !fifo_empty;
   assign overflow      = overflow_q;
   assign dropped_count = drop_q;
   assign fifo_level    = level_q;

endmodule
